mem_burst_reader: RTL and testbench

- Parametrised successor to the single-word memory reader in the dot-product datapath.
- Reads a programmable burst of consecutive addresses from NUM_CH synchronous-read memories in lockstep (e.g. vector A and vector B), with address wrap.
- Delivers each address's NUM_CH words as one beat on a valid/ready stream, through an internal credit-managed output FIFO, so the downstream multiply-accumulate stage can apply backpressure without losing data.

---
 rtl/mem_burst_reader.sv | 207 ++++++++++++++++++++
 tb/tb_mem_burst_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Burst reader: streams NUM_CH lockstep memories as valid/ready beats.
// Output FIFO is credit-managed so downstream backpressure never drops data.
module mem_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_SIZE   = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          length,
    output logic                         busy,
    output logic                         done,
    output logic                         read_en,
    output logic [ADDR_WIDTH-1:0]        read_address,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int BW = NUM_CH * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = ADDR_WIDTH + 1;

    localparam logic [LW-1:0]         MAX_LEN   = LW'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_read_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]         r_issued;
    logic [LW-1:0]         r_len;
    logic                  r_rd_last;
    logic                  r_rd_d;
    logic                  r_rd_last_d;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_read_en_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [LW-1:0]         w_issued_nxt;
    logic [LW-1:0]         w_len_nxt;
    logic                  w_rd_last_nxt;

    logic [BW-1:0]         r_q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_q_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_out_valid;

    logic [BW-1:0]         w_up_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] w_up_last;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_wr_idx;

    logic [LW-1:0]         w_len_clamp;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [LW-1:0]         w_issued_inc;
    logic                  w_credit;
    logic                  w_more;
    logic                  w_issue;

    assign w_push    = r_rd_d;
    assign w_pop     = r_out_valid & out_ready;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_wr_idx  = r_cnt - CW'(w_pop);

    assign w_len_clamp  = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_addr_inc   = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_issued_inc = r_issued + 1'b1;
    assign w_more       = r_issued < r_len;
    assign w_credit     = ({1'b0, w_cnt_nxt} + (CW + 1)'(r_read_en)) < DEPTH_C;
    assign w_issue      = (r_state == S_READ) && w_more && w_credit;

    assign busy         = r_busy;
    assign done         = r_done;
    assign read_en      = r_read_en;
    assign read_address = r_addr;
    assign out_valid    = r_out_valid;
    assign out_data     = r_q_data[0];
    assign out_last     = r_q_last[0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: leave READ once every address is issued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (!w_more || (w_issue && (w_issued_inc == r_len)))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && r_q_last[0])
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: next read strobe, address and issue bookkeeping
    always_comb begin
        w_read_en_nxt = 1'b0;
        w_addr_nxt    = r_addr;
        w_issued_nxt  = r_issued;
        w_len_nxt     = r_len;
        w_rd_last_nxt = 1'b0;
        if (r_state == S_IDLE && start) begin
            w_len_nxt = w_len_clamp;
            if (w_len_clamp != '0) begin
                w_read_en_nxt = 1'b1;
                w_addr_nxt    = base_addr;
                w_issued_nxt  = LW'(1);
                w_rd_last_nxt = (w_len_clamp == LW'(1));
            end
        end else if (w_issue) begin
            w_read_en_nxt = 1'b1;
            w_addr_nxt    = w_addr_inc;
            w_issued_nxt  = w_issued_inc;
            w_rd_last_nxt = (w_issued_inc == r_len);
        end
    end

    // Registered control outputs and the one-cycle read-data pipeline tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_en   <= 1'b0;
            r_addr      <= '0;
            r_issued    <= '0;
            r_len       <= '0;
            r_rd_last   <= 1'b0;
            r_rd_d      <= 1'b0;
            r_rd_last_d <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_read_en   <= w_read_en_nxt;
            r_addr      <= w_addr_nxt;
            r_issued    <= w_issued_nxt;
            r_len       <= w_len_nxt;
            r_rd_last   <= w_rd_last_nxt;
            r_rd_d      <= r_read_en;
            r_rd_last_d <= r_read_en & r_rd_last;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    // Shift-down view of the FIFO used when the head is popped
    always_comb begin
        w_up_data = r_q_data;
        for (int i = 0; i < FIFO_DEPTH - 1; i++)
            w_up_data[i] = r_q_data[i + 1];
        w_up_last = {r_q_last[FIFO_DEPTH-1], r_q_last[FIFO_DEPTH-1:1]};
    end

    // Output FIFO: slot 0 is the registered stream head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_q_last    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_q_data[i] <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= (w_cnt_nxt != '0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_push && (w_wr_idx == CW'(i))) begin
                    r_q_data[i] <= data_in;
                    r_q_last[i] <= r_rd_last_d;
                end else if (w_pop) begin
                    r_q_data[i] <= w_up_data[i];
                    r_q_last[i] <= w_up_last[i];
                end
            end
            if (w_cnt_nxt == '0)
                r_q_last[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: table bursts, corner sequences, random bursts.
// Expected beats come from an address/data model of the memories.
module tb_mem_burst_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MS = 32;
    localparam int NC = 2;
    localparam int FD = 4;
    localparam int BW = NC * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic          read_en;
    logic [AW-1:0] read_address;
    logic [BW-1:0] data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    mem_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS),
        .NUM_CH(NC), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .read_en(read_en),
        .read_address(read_address), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    logic [DW-1:0] mem0 [MS];
    logic [DW-1:0] mem1 [MS];

    // synchronous-read memories; junk on cycles without a read
    always @(posedge clk) begin
        if (read_en) data_in <= {mem1[read_address], mem0[read_address]};
        else         data_in <= {$urandom(), $urandom()};
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] rd_q [$];
    int            rd_cyc [$];
    logic [BW:0]   bt_q [$];
    int            bt_cyc [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            vld_seen = 0;
    int            outstanding = 0;
    logic          p_stall = 1'b0;
    logic [BW:0]   p_beat = '0;

    // stream monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_stall) begin
                checks++;
                if (!out_valid || ({out_last, out_data} !== p_beat)) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b %h required %h",
                             out_valid, {out_last, out_data}, p_beat);
                end
            end
            p_stall = out_valid && !out_ready;
            p_beat  = {out_last, out_data};
            if (read_en) begin
                rd_q.push_back(read_address);
                rd_cyc.push_back(cyc);
                outstanding++;
            end
            if (out_valid) vld_seen++;
            if (out_valid && out_ready) begin
                bt_q.push_back({out_last, out_data});
                bt_cyc.push_back(cyc);
                outstanding--;
            end
            if (outstanding > FD) begin
                checks++;
                errors++;
                $display("FAIL fifo_credit got %0d outstanding required <= %0d",
                         outstanding, FD);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        rd_cyc.delete();
        bt_q.delete();
        bt_cyc.delete();
        done_cnt    = 0;
        vld_seen    = 0;
        outstanding = 0;
    endtask

    function automatic int clamp_len(input int l);
        return (l > MS) ? MS : l;
    endfunction

    function automatic logic [BW:0] exp_beat(input int b, input int n,
                                             input int k);
        int a;
        a = (b + k) % MS;
        return {(k == n - 1), mem1[a], mem0[a]};
    endfunction

    // mode 0: ready=1; 1: random ready; 2: ready=0 for 10 cycles then 1
    task automatic run_burst(input int b, input int l, input int mode,
                             input int restart_at, output int acc);
        int t;
        clear_mon();
        base_addr = AW'(b);
        length    = (AW + 1)'(l);
        out_ready = (mode != 2);
        start     = 1'b1;
        tick();
        acc       = cyc;
        start     = 1'b0;
        base_addr = AW'($urandom());
        length    = (AW + 1)'($urandom());
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            if (t == restart_at) begin
                start     = 1'b1;
                base_addr = AW'(20);
                length    = (AW + 1)'(3);
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && t == 10)
                chk("bp_issues", rd_q.size(), FD);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (t >= 10);
            endcase
            tick();
            t++;
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout got no done required done");
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic verify(input int b, input int l);
        int n;
        n = clamp_len(l);
        chk("rd_count", rd_q.size(), n);
        for (int k = 0; k < n && k < rd_q.size(); k++)
            chk("rd_addr", rd_q[k], (b + k) % MS);
        chk("beat_count", bt_q.size(), n);
        for (int k = 0; k < n && k < bt_q.size(); k++)
            chk("beat", bt_q[k], exp_beat(b, n, k));
        chk("done_count", done_cnt, 1);
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int nbeats;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int acc;
        int b;
        int l;
        int t;

        tbl = '{
            '{0,  4,  0, 4},
            '{30, 4,  0, 4},
            '{8,  8,  2, 8},
            '{7,  40, 1, 32},
            '{31, 1,  0, 1},
            '{0,  32, 1, 32},
            '{12, 0,  0, 0}
        };

        for (int i = 0; i < MS; i++) begin
            mem0[i] = DW'(i);
            mem1[i] = DW'(100 + i);
        end

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_outs", {busy, done, read_en, out_valid, out_last}, 0);
        chk("rst_addr", read_address, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // throughput and exact latency
        run_burst(0, 4, 0, -1, acc);
        verify(0, 4);
        for (int k = 0; k < 4 && k < rd_cyc.size(); k++)
            chk("rd_cycle", rd_cyc[k] - acc, k);
        for (int k = 0; k < 4 && k < bt_cyc.size(); k++)
            chk("beat_cycle", bt_cyc[k] - acc, 2 + k);
        chk("done_cycle", done_cyc - acc, 6);

        // table-driven bursts
        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].base, tbl[i].len, tbl[i].mode, -1, acc);
            chk("tbl_beats", bt_q.size(), tbl[i].nbeats);
            verify(tbl[i].base, tbl[i].len);
        end

        // zero length: no traffic, done right after acceptance
        run_burst(12, 0, 0, -1, acc);
        chk("zero_valid", vld_seen, 0);
        chk("zero_done_lat", (done_cyc - acc) <= 1, 1);

        // second start while busy is ignored
        run_burst(3, 6, 0, 2, acc);
        verify(3, 6);

        // reset during the third beat
        clear_mon();
        base_addr = AW'(0);
        length    = (AW + 1)'(8);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (bt_q.size() < 2 && t < 100) begin
            tick();
            t++;
        end
        chk("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {busy, done, read_en, out_valid, out_last}, 0);
        chk("rst_mid_addr", read_address, 0);
        chk("rst_mid_data", out_data, 0);
        tick();
        tick();
        chk("rst_mid_done", done_cnt, 0);
        rst_n = 1'b1;
        tick();
        run_burst(5, 2, 0, -1, acc);
        verify(5, 2);

        // randomized bursts over random memory contents
        for (int i = 0; i < MS; i++) begin
            mem0[i] = $urandom();
            mem1[i] = $urandom();
        end
        for (int r = 0; r < 25; r++) begin
            b = $urandom_range(0, MS - 1);
            l = $urandom_range(0, 40);
            run_burst(b, l, $urandom_range(0, 1), -1, acc);
            verify(b, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
